// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-type encodings and FSM state for the load/store unit.
// Holds the RW_* memory type codes and the lsu_state_e enum used by lsu_ctrl.
package lsu_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake between the EX/MEM stage and the LSU.
// master = requester (drives req_*), slave = lsu_ctrl (drives req_ready, rsp_*).
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr, req_type, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_type, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational helpers for the LSU.
// In: type/addr to classify, word+index to pick a byte, type+word to extend.
// Out: misalign flag, last beat index, selected byte, extended load data.
module lsu_align (
    input  logic [1:0]  chk_size,
    input  logic [1:0]  chk_addr_lo,
    output logic        misalign,
    output logic [1:0]  last_beat,
    input  logic [31:0] sel_word,
    input  logic [1:0]  sel_idx,
    output logic [7:0]  sel_byte,
    input  logic [2:0]  ext_type,
    input  logic [31:0] ext_word,
    output logic [31:0] ext_data
);
    import lsu_pkg::*;

    always_comb begin
        misalign  = 1'b0;
        last_beat = 2'd0;
        if (chk_size[1]) begin
            misalign  = |chk_addr_lo;
            last_beat = misalign ? 2'd3 : 2'd0;
        end else if (chk_size[0]) begin
            misalign  = chk_addr_lo[0];
            last_beat = {1'b0, misalign};
        end
    end

    assign sel_byte = sel_word[{sel_idx, 3'b000} +: 8];

    // type[2] selects zero extension; word passes through untouched
    always_comb begin
        ext_data = ext_word;
        if (!ext_type[1]) begin
            if (ext_type[0])
                ext_data = ext_type[2] ? {16'd0, ext_word[15:0]}
                                       : {{16{ext_word[15]}}, ext_word[15:0]};
            else
                ext_data = ext_type[2] ? {24'd0, ext_word[7:0]}
                                       : {{24{ext_word[7]}}, ext_word[7:0]};
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator for the word-organised data memory port.
// Ports: clk, rst (sync, active-high), bus (lsu_ctrl_if.slave), mem_* data port.
module lsu_ctrl #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    lsu_ctrl_if.slave   bus,
    output logic        mem_wr_en,
    output logic [2:0]  mem_rw_type,
    output logic [31:0] mem_data_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    import lsu_pkg::*;

    lsu_state_e  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  last_q, last_d;
    logic        split_q, split_d;
    logic        wr_q, wr_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [2:0]  mem_rw_type_q, mem_rw_type_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;

    logic        misalign;
    logic [1:0]  last_beat;
    logic [31:0] sel_word;
    logic [1:0]  sel_idx;
    logic [7:0]  sel_byte;
    logic [31:0] asm_ld;
    logic [31:0] ext_data;

    // In IDLE the byte picker serves beat 0 of the incoming request;
    // in ACCESS it prepares the next beat from the latched data.
    assign sel_word = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign sel_idx  = (state_q == IDLE) ? 2'd0 : beat_q + 2'd1;

    always_comb begin
        asm_ld = asm_q;
        asm_ld[{beat_q, 3'b000} +: 8] = mem_data_out[7:0];
    end

    lsu_align u_align (
        .chk_size    (bus.req_type[1:0]),
        .chk_addr_lo (bus.req_addr[1:0]),
        .misalign    (misalign),
        .last_beat   (last_beat),
        .sel_word    (sel_word),
        .sel_idx     (sel_idx),
        .sel_byte    (sel_byte),
        .ext_type    (type_q),
        .ext_word    (asm_ld),
        .ext_data    (ext_data)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        last_d        = last_q;
        split_d       = split_q;
        wr_d          = wr_q;
        type_d        = type_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        asm_d         = asm_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = 1'b0;
        mem_wr_en_d   = mem_wr_en_q;
        mem_rw_type_d = mem_rw_type_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    type_d  = bus.req_type;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    beat_d  = 2'd0;
                    asm_d   = 32'd0;
                    split_d = misalign;
                    last_d  = last_beat;
                    if (misalign && !ALLOW_MISALIGN) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d     = ACCESS;
                        mem_wr_en_d = bus.req_wr;
                        mem_addr_d  = bus.req_addr;
                        if (misalign) begin
                            mem_rw_type_d = bus.req_wr ? RW_B : RW_BU;
                            mem_din_d     = {24'd0, sel_byte};
                        end else begin
                            mem_rw_type_d = bus.req_type;
                            mem_din_d     = bus.req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (split_q)
                    asm_d = asm_ld;
                if (beat_q == last_q) begin
                    state_d     = RESP;
                    mem_wr_en_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (wr_q)
                        rsp_rdata_d = 32'd0;
                    else if (split_q)
                        rsp_rdata_d = ext_data;
                    else
                        rsp_rdata_d = mem_data_out;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    mem_addr_d = addr_q + {30'd0, beat_d};
                    mem_din_d  = {24'd0, sel_byte};
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_q        <= 2'd0;
            last_q        <= 2'd0;
            split_q       <= 1'b0;
            wr_q          <= 1'b0;
            type_q        <= RW_W;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            asm_q         <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rw_type_q <= RW_W;
            mem_addr_q    <= 32'd0;
            mem_din_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            last_q        <= last_d;
            split_q       <= split_d;
            wr_q          <= wr_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            asm_q         <= asm_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rw_type_q <= mem_rw_type_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // strobe killed immediately on reset so an in-flight beat never lands
    assign mem_wr_en     = mem_wr_en_q & ~rst;
    assign mem_rw_type   = mem_rw_type_q;
    assign mem_data_addr = mem_addr_q;
    assign mem_data_in   = mem_din_q;

endmodule
